// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions used by both the master and slave sides.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [1:0] RESP_EXOKAY      = 2'b01;
    localparam logic [1:0] RESP_SLVERR      = 2'b10;
    localparam logic [1:0] RESP_DECERR      = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_lstm_master.sv
// AXI4-Lite master: turns one command at a time into a single AXI4-Lite
// read or write and hands the slave's answer back on a response handshake.
// A sticky timeout flag reports any transaction that stays busy too long;
// the transaction itself is never abandoned.
module axi4_lite_lstm_master #(
    parameter int TIMEOUT    = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_data,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_write,

    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,

    output logic                  timeout
);

    import axi4_lite_pkg::*;

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_WR_ADDR_DATA = 3'd1;
    localparam logic [2:0] S_WR_RESP      = 3'd2;
    localparam logic [2:0] S_RD_ADDR      = 3'd3;
    localparam logic [2:0] S_RD_DATA      = 3'd4;
    localparam logic [2:0] S_RESP         = 3'd5;

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [CW-1:0]         busy_cnt;
    logic                  accept;
    logic                  busy;

    // cmd_ready depends only on state; it is held low while reset is applied
    assign cmd_ready = (state == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != S_IDLE) && (state != S_RESP);

    assign awaddr = addr_q;
    assign araddr = addr_q;
    assign wdata  = data_q;
    assign awprot = AXI_PROT_DEFAULT;
    assign arprot = AXI_PROT_DEFAULT;
    assign wstrb  = 4'hF;

    // Address and data are captured once per command and stay put while any valid is up
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= cmd_addr;
            data_q <= cmd_data;
        end
    end

    // Transaction FSM; AW and W are retired independently, a low valid means its beat is done
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_resp  <= 2'b00;
            rsp_write <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        rsp_write <= cmd_write;
                        if (cmd_write) begin
                            state   <= S_WR_ADDR_DATA;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            state   <= S_RD_ADDR;
                            arvalid <= 1'b1;
                        end
                    end
                end
                S_WR_ADDR_DATA: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        state  <= S_WR_RESP;
                        bready <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= 32'h0;
                        rsp_resp  <= bresp;
                        rsp_write <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= rdata;
                        rsp_resp  <= rresp;
                        rsp_write <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Busy-cycle counter; the flag is registered so it shows from the cycle after the limit is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
            timeout  <= 1'b0;
        end else if (accept) begin
            busy_cnt <= '0;
        end else if (busy) begin
            if (busy_cnt != CW'(TIMEOUT)) busy_cnt <= busy_cnt + 1'b1;
            if (busy_cnt >= CW'(TIMEOUT - 1)) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi4_lite_lstm_master.sv
// Self-checking bench for axi4_lite_lstm_master: the bench plays the AXI
// slave with chosen handshake delays and predicts every response from
// the command alone.
module tb_axi4_lite_lstm_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_data;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    bit exp_timeout = 1'b0;

    axi4_lite_lstm_master #(.TIMEOUT(TO), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One command end to end; the bench acts as slave, starting and ending just after a negedge.
    // addr_dly/data_dly: cycles each valid is seen high (handshake on the last one);
    // resp_dly: cycles bready/rready is seen high before the slave answers;
    // rsp_dly: cycles rsp_valid is seen high before rsp_ready is given.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                 input int addr_dly, input int data_dly, input int resp_dly,
                                 input logic [31:0] rd_val, input logic [1:0] resp_val,
                                 input int rsp_dly, input bit rst_at_bready, input string tag);
        int aw_seen = 0, w_seen = 0, ar_seen = 0, b_seen = 0, r_seen = 0, rsp_seen = 0;
        int cyc = 0, busy = 0;
        bit finished = 1'b0, aborted = 1'b0;
        logic [31:0] exp_data = wr ? 32'h0 : rd_val;

        while (!cmd_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, " cmd_ready_idle"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(1, 0));
        cmd_addr  = $urandom;
        cmd_data  = $urandom;

        cyc = 0;
        while (!finished && !aborted && cyc < 80) begin
            checkOutput({tag, " timeout"}, 64'(timeout), 64'(exp_timeout));
            checkOutput({tag, " cmd_ready_busy"}, 64'(cmd_ready), 64'(0));
            if (wr) begin
                checkOutput({tag, " read_quiet"}, 64'({arvalid, rready}), 64'(0));
                if (awvalid) begin
                    aw_seen++;
                    checkOutput({tag, " awaddr"}, 64'(awaddr), 64'(addr));
                    checkOutput({tag, " awprot"}, 64'(awprot), 64'(0));
                end
                awready = awvalid && (aw_seen == addr_dly);
                if (wvalid) begin
                    w_seen++;
                    checkOutput({tag, " wdata"}, 64'({wstrb, wdata}), 64'({4'hF, data}));
                end
                wready = wvalid && (w_seen == data_dly);
                bvalid = 1'b0;
                bresp  = 2'($urandom_range(3, 0));
                if (bready) begin
                    b_seen++;
                    checkOutput({tag, " bready_after_aw_w"}, 64'({awvalid, wvalid}), 64'(0));
                    if (rst_at_bready) begin
                        rst     = 1'b1;
                        bvalid  = 1'b1;
                        bresp   = 2'b00;
                        aborted = 1'b1;
                    end else if (b_seen == resp_dly) begin
                        bvalid = 1'b1;
                        bresp  = resp_val;
                    end
                end
            end else begin
                checkOutput({tag, " write_quiet"}, 64'({awvalid, wvalid, bready}), 64'(0));
                if (arvalid) begin
                    ar_seen++;
                    checkOutput({tag, " araddr"}, 64'({arprot, araddr}), 64'({3'b000, addr}));
                end
                arready = arvalid && (ar_seen == addr_dly);
                rvalid  = 1'b0;
                rdata   = $urandom;
                rresp   = 2'($urandom_range(3, 0));
                if (rready) begin
                    r_seen++;
                    if (r_seen == resp_dly) begin
                        rvalid = 1'b1;
                        rdata  = rd_val;
                        rresp  = resp_val;
                    end
                end
            end
            rsp_ready = 1'b0;
            if (rsp_valid) begin
                rsp_seen++;
                checkOutput({tag, " rsp_data"}, 64'(rsp_data), 64'(exp_data));
                checkOutput({tag, " rsp_resp"}, 64'(rsp_resp), 64'(resp_val));
                checkOutput({tag, " rsp_write"}, 64'(rsp_write), 64'(wr));
                if (rsp_seen == rsp_dly) begin
                    rsp_ready = 1'b1;
                    finished  = 1'b1;
                end
            end else begin
                busy++;
                if (busy >= TO) exp_timeout = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end

        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rsp_ready = 1'b0;

        if (aborted) begin
            exp_timeout = 1'b0;
            checkOutput({tag, " rst_valids"}, 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, timeout}), 64'(0));
            checkOutput({tag, " rst_rsp_regs"}, 64'({rsp_resp, rsp_data}), 64'(0));
            checkOutput({tag, " rst_cmd_ready"}, 64'(cmd_ready), 64'(0));
            rst = 1'b0;
            #1;
            checkOutput({tag, " post_rst_cmd_ready"}, 64'(cmd_ready), 64'(1));
            repeat (3) begin
                @(negedge clk);
                checkOutput({tag, " no_rsp_after_rst"}, 64'({rsp_valid, cmd_ready}), 64'(1));
            end
        end else begin
            checkOutput({tag, " completed_in_budget"}, 64'(finished), 64'(1));
            checkOutput({tag, " rsp_dropped"}, 64'(rsp_valid), 64'(0));
            checkOutput({tag, " back_to_idle"}, 64'(cmd_ready), 64'(1));
            checkOutput({tag, " rsp_hold_cycles"}, 64'(rsp_seen), 64'(rsp_dly));
            if (wr) begin
                checkOutput({tag, " awvalid_cycles"}, 64'(aw_seen), 64'(addr_dly));
                checkOutput({tag, " wvalid_cycles"}, 64'(w_seen), 64'(data_dly));
                checkOutput({tag, " bready_cycles"}, 64'(b_seen), 64'(resp_dly));
            end else begin
                checkOutput({tag, " arvalid_cycles"}, 64'(ar_seen), 64'(addr_dly));
                checkOutput({tag, " rready_cycles"}, 64'(r_seen), 64'(resp_dly));
            end
        end
    endtask

    // Directed scenarios first, then randomized traffic after the reset scenario clears the sticky flag
    initial begin
        bit          r_wr;
        logic [31:0] r_addr, r_data, r_val;
        logic [1:0]  r_resp;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;

        repeat (3) @(negedge clk);
        checkOutput("reset_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, timeout}), 64'(0));
        checkOutput("reset_rsp_regs", 64'({rsp_resp, rsp_data}), 64'(0));
        checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'(0));
        rst = 1'b0;
        #1;
        checkOutput("idle_cmd_ready", 64'(cmd_ready), 64'(1));

        applyStimulus(1'b1, 32'h0000_0000, 32'h0000_1234, 3, 1, 1, 32'h0, 2'b00, 1, 1'b0, "wr_aw_delayed");
        applyStimulus(1'b0, 32'h0000_0088, 32'h0,         1, 1, 2, 32'hDEAD_BEEF, 2'b00, 1, 1'b0, "rd_basic");
        applyStimulus(1'b1, 32'h0000_0010, 32'hA5A5_0001, 1, 1, 1, 32'h0, 2'b10, 1, 1'b0, "wr_slverr");
        applyStimulus(1'b0, 32'h0000_0014, 32'h0,         1, 1, 1, 32'h1357_9BDF, 2'b11, 1, 1'b0, "rd_decerr");
        applyStimulus(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 2, 2, 2, 32'h0, 2'b01, 1, 1'b0, "wr_same_cycle");
        applyStimulus(1'b1, 32'h0000_0024, 32'hCAFE_0024, 1, 3, 1, 32'h0, 2'b00, 1, 1'b0, "wr_w_late");
        applyStimulus(1'b0, 32'h0000_0030, 32'h0,         2, 1, 1, 32'h0F0F_F0F0, 2'b00, 6, 1'b0, "rd_rsp_stall");
        applyStimulus(1'b0, 32'h0000_0040, 32'h0,         11, 1, 1, 32'h7777_1111, 2'b00, 1, 1'b0, "rd_timeout");
        checkOutput("timeout_sticky", 64'(timeout), 64'(1));
        applyStimulus(1'b1, 32'h0000_0050, 32'h5555_AAAA, 1, 1, 1, 32'h0, 2'b00, 1, 1'b1, "wr_reset_in_resp");
        applyStimulus(1'b1, 32'h0000_0054, 32'h1111_2222, 1, 2, 1, 32'h0, 2'b00, 1, 1'b0, "wr_after_reset");

        for (int i = 0; i < 12; i++) begin
            r_wr   = 1'($urandom_range(1, 0));
            r_addr = $urandom;
            r_data = $urandom;
            r_val  = $urandom;
            r_resp = 2'($urandom_range(3, 0));
            applyStimulus(r_wr, r_addr, r_data, int'($urandom_range(3, 1)), int'($urandom_range(3, 1)),
                          int'($urandom_range(3, 1)), r_val, r_resp, int'($urandom_range(3, 1)), 1'b0, "random");
        end

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
